// File: rtl/pipe_issue_arbiter.sv
// pipe_issue_arbiter
// Round-robin issue arbiter for two requesters sharing one fixed-latency
// pipeline. Launches the winning operand, tracks the owner of every
// in-flight operation through DEPTH stages, returns per-requester completion
// pulses and enforces a per-requester in-flight credit limit.
module pipe_issue_arbiter #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              gnt_a,
  output logic              done_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_b,
  output logic              done_b,
  input  logic              stall,
  input  logic              flush,
  output logic              pipe_valid,
  output logic [DATA_W-1:0] pipe_data,
  output logic              pipe_src,
  output logic              busy
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

  typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_t;

  pri_t ptr_q, ptr_nxt;

  logic [CW-1:0]     cnt_a, cnt_b;
  logic [DEPTH-1:0]  trk_vld, trk_src;

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic              src_p0;

  logic shift_en;
  logic issue_ok;
  logic elig_a, elig_b;
  logic grant;
  logic exit_a, exit_b;

  // Credit update: +1 on grant, -1 on completion, unchanged when both.
  // The guards keep the counter from wrapping in either direction.
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cnt,
                                                input logic          inc,
                                                input logic          dec);
    logic [CW-1:0] res;
    res = cnt;
    if (inc && !dec && (cnt != MAX_C))
      res = cnt + CW'(1);
    else if (dec && !inc && (cnt != '0))
      res = cnt - CW'(1);
    return res;
  endfunction

  assign shift_en = ena & ~stall;
  // Reset is folded in so that gnt is low while the block is held in reset.
  assign issue_ok = rst_n & shift_en & ~flush;
  assign elig_a   = req_a & (cnt_a < MAX_C) & issue_ok;
  assign elig_b   = req_b & (cnt_b < MAX_C) & issue_ok;
  assign grant    = gnt_a | gnt_b;

  // Operations leave the last tracker stage only in a shifting, non-flushed cycle.
  assign exit_a = shift_en & ~flush & trk_vld[DEPTH-1] & ~trk_src[DEPTH-1];
  assign exit_b = shift_en & ~flush & trk_vld[DEPTH-1] &  trk_src[DEPTH-1];

  assign busy       = |trk_vld;
  assign pipe_valid = vld_p0;
  assign pipe_data  = data_p0;
  assign pipe_src   = src_p0;

  // Arbitration: single eligible side wins; contested grant goes to the pointer side and flips it.
  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    ptr_nxt = ptr_q;
    if (elig_a && elig_b) begin
      if (ptr_q == PRI_A) begin
        gnt_a   = 1'b1;
        ptr_nxt = PRI_B;
      end else begin
        gnt_b   = 1'b1;
        ptr_nxt = PRI_A;
      end
    end else begin
      gnt_a = elig_a;
      gnt_b = elig_b;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PRI_A;
    else        ptr_q <= ptr_nxt;
  end

  // ---- stage p0: launch register into the shared pipeline ----
  // Launch register: strobe on grant, operand and source captured only when launching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      src_p0  <= 1'b0;
    end else begin
      vld_p0 <= grant;
      if (grant) begin
        data_p0 <= gnt_b ? data_b : data_a;
        src_p0  <= gnt_b;
      end
    end
  end

  // In-flight tracker: {valid, src} shift register frozen on stall/ena-low, cleared on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_vld <= '0;
      trk_src <= '0;
    end else if (flush) begin
      trk_vld <= '0;
      trk_src <= '0;
    end else if (shift_en) begin
      trk_vld <= {trk_vld[DEPTH-2:0], grant};
      trk_src <= {trk_src[DEPTH-2:0], gnt_b};
    end
  end

  // Completion pulses, one cycle, for operations leaving the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_a <= 1'b0;
      done_b <= 1'b0;
    end else begin
      done_a <= exit_a;
      done_b <= exit_b;
    end
  end

  // Per-requester credit counters; flush returns every credit at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (flush) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      cnt_a <= credit_next(cnt_a, gnt_a, exit_a);
      cnt_b <= credit_next(cnt_b, gnt_b, exit_b);
    end
  end

endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// Testbench for pipe_issue_arbiter (DATA_W=8, DEPTH=4, MAX_OUT=2).
// The driver pushes expected launches and completions into queues; a monitor
// on the falling edge pops and compares whenever the DUT presents them.
module tb_pipe_issue_arbiter;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              req_a, req_b;
  logic [DATA_W-1:0] data_a, data_b;
  logic              gnt_a, gnt_b;
  logic              done_a, done_b;
  logic              stall, flush;
  logic              pipe_valid;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_src;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int              cyc;
    logic [DATA_W-1:0] data;
    logic            src;
  } launch_t;

  launch_t lq[$];
  int      qa[$];
  int      qb[$];

  pipe_issue_arbiter #(.DATA_W(8), .DEPTH(4), .MAX_OUT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .req_a     (req_a),
    .data_a    (data_a),
    .gnt_a     (gnt_a),
    .done_a    (done_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .gnt_b     (gnt_b),
    .done_b    (done_b),
    .stall     (stall),
    .flush     (flush),
    .pipe_valid(pipe_valid),
    .pipe_data (pipe_data),
    .pipe_src  (pipe_src),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus. Expected grants are checked directly; a grant
  // pushes its launch (next cycle) and its completion (lat cycles after the
  // decision cycle, lat=0 means the op is discarded and never completes).
  task automatic step(input logic ra, input logic [7:0] da,
                      input logic rb, input logic [7:0] db,
                      input logic st, input logic fl, input logic en,
                      input logic ega, input logic egb, input int lat);
    launch_t e;
    req_a = ra; data_a = da; req_b = rb; data_b = db;
    stall = st; flush = fl; ena = en;
    #1;
    chk("gnt_a", gnt_a, ega);
    chk("gnt_b", gnt_b, egb);
    if (ega) begin
      e.cyc = cyc + 1; e.data = da; e.src = 1'b0;
      lq.push_back(e);
      if (lat > 0) qa.push_back(cyc + lat);
    end
    if (egb) begin
      e.cyc = cyc + 1; e.data = db; e.src = 1'b1;
      lq.push_back(e);
      if (lat > 0) qb.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
  endtask

  // Monitor: compares every presented launch and completion against the queues.
  always @(negedge clk) begin
    launch_t e;
    int      d;
    if (rst_n) begin
      if (lq.size() > 0 && lq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL launch_missing: expected at cycle %0d (now %0d)", lq[0].cyc, cyc);
        e = lq.pop_front();
      end
      if (pipe_valid) begin
        checks++;
        if (lq.size() == 0) begin
          errors++;
          $display("FAIL launch_unexpected: data %0h src %0d at cycle %0d", pipe_data, pipe_src, cyc);
        end else begin
          e = lq.pop_front();
          if (e.cyc != cyc || e.data !== pipe_data || e.src !== pipe_src) begin
            errors++;
            $display("FAIL launch: got cyc %0d data %0h src %0d expected cyc %0d data %0h src %0d",
                     cyc, pipe_data, pipe_src, e.cyc, e.data, e.src);
          end
        end
      end
      if (qa.size() > 0 && qa[0] < cyc) begin
        checks++; errors++;
        $display("FAIL done_a_missing: expected at cycle %0d (now %0d)", qa[0], cyc);
        d = qa.pop_front();
      end
      if (done_a) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL done_a_unexpected: pulse at cycle %0d", cyc);
        end else begin
          d = qa.pop_front();
          if (d != cyc) begin
            errors++;
            $display("FAIL done_a: got cycle %0d expected cycle %0d", cyc, d);
          end
        end
      end
      if (qb.size() > 0 && qb[0] < cyc) begin
        checks++; errors++;
        $display("FAIL done_b_missing: expected at cycle %0d (now %0d)", qb[0], cyc);
        d = qb.pop_front();
      end
      if (done_b) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL done_b_unexpected: pulse at cycle %0d", cyc);
        end else begin
          d = qb.pop_front();
          if (d != cyc) begin
            errors++;
            $display("FAIL done_b: got cycle %0d expected cycle %0d", cyc, d);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; ena = 1'b1; stall = 1'b0; flush = 1'b0;
    req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_pipe_valid", pipe_valid, 0);
    chk("rst_pipe_data", pipe_data, 0);
    chk("rst_pipe_src", pipe_src, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_done_b", done_b, 0);
    chk("rst_busy", busy, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single A op: launch next cycle, completion 4 edges after the grant edge.
    step(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5);
    chk("t1_busy_start", busy, 1);
    idle(3);
    chk("t1_busy_last", busy, 1);
    idle(1);
    chk("t1_busy_clear", busy, 0);
    idle(4);

    // Contention: A,B,A then B alone once A is out of credits.
    step(1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5);
    step(1'b1, 8'h13, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5);
    step(1'b1, 8'h13, 1'b1, 8'h24, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5);
    step(1'b1, 8'h15, 1'b1, 8'h24, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5);
    idle(8);

    // Credit limit: two grants, blocked until the first completion, then re-granted that cycle.
    step(1'b1, 8'h31, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5);
    step(1'b1, 8'h32, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5);
    step(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5);
    step(1'b1, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5);
    step(1'b1, 8'h35, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(8);

    // Freeze: two stall cycles and one ena-low cycle add three cycles of latency.
    step(1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8);
    step(1'b0, 8'h00, 1'b1, 8'h4B, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("t4_pv_frozen", pipe_valid, 0);
    chk("t4_busy_frozen", busy, 1);
    step(1'b0, 8'h00, 1'b1, 8'h4B, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 8'h00, 1'b1, 8'h4B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle(8);

    // Flush with three ops in flight: nothing completes, credits return.
    step(1'b1, 8'h51, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    step(1'b0, 8'h00, 1'b1, 8'h62, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    step(1'b1, 8'h53, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    step(1'b0, 8'h00, 1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    chk("t5_busy_flushed", busy, 0);
    chk("t5_pv_flushed", pipe_valid, 0);
    step(1'b0, 8'h00, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5);
    step(1'b1, 8'h57, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5);
    step(1'b1, 8'h58, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5);
    idle(8);

    // Reset mid-flight: pointer is on B from the contention test.
    step(1'b1, 8'h71, 1'b1, 8'h72, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5);
    step(1'b1, 8'h71, 1'b1, 8'h73, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5);
    req_a = 1'b0; req_b = 1'b0;
    chk("t6_pv_before_rst", pipe_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    lq.delete(); qa.delete(); qb.delete();
    chk("t6_rst_pipe_valid", pipe_valid, 0);
    chk("t6_rst_pipe_data", pipe_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done_a", done_a, 0);
    chk("t6_rst_done_b", done_b, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 8'h81, 1'b1, 8'h82, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5);
    step(1'b1, 8'h83, 1'b1, 8'h82, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5);
    idle(10);

    chk("end_busy", busy, 0);
    chk("end_launch_queue", lq.size(), 0);
    chk("end_done_a_queue", qa.size(), 0);
    chk("end_done_b_queue", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
